// File: rtl/inst_buffer_if.sv
// Fetch/dispatch-side signal bundle for inst_buffer; the buffer takes the slave modport,
// the fetch/dispatch environment drives the master modport.
interface inst_buffer_if #(
  parameter int N       = 3,
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 128
);
  localparam int DC_W  = $clog2(N + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                 flush;
  logic [N-1:0]         in_valid;
  logic [N*ENTRY_W-1:0] in_entries;
  logic                 in_ready;
  logic [N-1:0]         out_valid;
  logic [N*ENTRY_W-1:0] out_entries;
  logic [DC_W-1:0]      dispatch_count;
  logic [OCC_W-1:0]     occupancy;

  modport master (
    output flush, in_valid, in_entries, dispatch_count,
    input  in_ready, out_valid, out_entries, occupancy
  );

  modport slave (
    input  flush, in_valid, in_entries, dispatch_count,
    output in_ready, out_valid, out_entries, occupancy
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch/decode and dispatch: compacts N-wide bundles in,
// presents the oldest N entries out. Optional same-cycle bypass when empty: IBUF_BYPASS_EN.
module inst_buffer #(
  parameter int N       = 3,
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 128
) (
  input  logic          clock,
  input  logic          reset,
  inst_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // NOTE: storage carries no reset; only head/tail/count define which entries are live.
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;

  logic [ENTRY_W-1:0] comp [N];
  logic [CNT_W-1:0]   push_cnt;
  logic               accept;
  logic               bypass;
  logic [CNT_W-1:0]   valid_cnt;
  logic [CNT_W-1:0]   req_cnt;
  logic [CNT_W-1:0]   pop;
  logic [CNT_W-1:0]   skip;
  logic [CNT_W-1:0]   pushed;
  logic [N-1:0]       ov_inc;

  // Pack the set in_valid slots into comp[0..push_cnt-1], preserving slot order.
  always_comb begin
    int k;
    // NOTE: every comb output gets a default up front so no path can infer a latch.
    for (int j = 0; j < N; j++) comp[j] = '0;
    k = 0;
    // NOTE: blocking assignments here: k must update within the loop iteration.
    for (int i = 0; i < N; i++) begin
      if (bus.in_valid[i]) begin
        comp[k] = bus.in_entries[i*ENTRY_W +: ENTRY_W];
        k = k + 1;
      end
    end
    push_cnt = CNT_W'(k);
  end

  // Credit is based on registered count only; pops in the same cycle are not counted.
  assign bus.in_ready = reset && !bus.flush && (count <= CNT_W'(DEPTH - N));
  assign accept       = bus.in_ready && (|bus.in_valid);
  assign pushed       = accept ? push_cnt : '0;

`ifdef IBUF_BYPASS_EN
  assign bypass = accept && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    bus.out_valid   = '0;
    bus.out_entries = '0;
    valid_cnt       = '0;
    if (reset) begin
      if (bypass) begin
        valid_cnt = push_cnt;
        for (int i = 0; i < N; i++) begin
          if (CNT_W'(i) < push_cnt) begin
            bus.out_valid[i]                     = 1'b1;
            bus.out_entries[i*ENTRY_W +: ENTRY_W] = comp[i];
          end
        end
      end else begin
        valid_cnt = (count > CNT_W'(N)) ? CNT_W'(N) : count;
        for (int i = 0; i < N; i++) begin
          if (CNT_W'(i) < count) begin
            bus.out_valid[i]                     = 1'b1;
            bus.out_entries[i*ENTRY_W +: ENTRY_W] = mem[head + PTR_W'(i)];
          end
        end
      end
    end
  end

  assign req_cnt = CNT_W'(bus.dispatch_count);
  assign pop     = (req_cnt < valid_cnt) ? req_cnt : valid_cnt;
  // Bypassed entries that dispatch takes this cycle never touch storage.
  assign skip    = bypass ? pop : '0;

  always_ff @(posedge clock) begin
    if (!reset || bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= bypass ? head : head + PTR_W'(pop);
      tail  <= tail + PTR_W'(pushed - skip);
      count <= count + pushed - pop;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (CNT_W'(k) >= skip && CNT_W'(k) < push_cnt) begin
          mem[tail + PTR_W'(CNT_W'(k) - skip)] <= comp[k];
        end
      end
    end
  end

  assign bus.occupancy = count;
  assign ov_inc        = bus.out_valid + N'(1);

  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    count <= CNT_W'(DEPTH));

  a_out_thermo: assert property (@(posedge clock) disable iff (!reset)
    (bus.out_valid & ov_inc) == '0);

  // Dispatch asking for more than is presented is clamped, but is still a caller bug.
  a_dispatch_clamp: assert property (@(posedge clock) disable iff (!reset || bus.flush)
    req_cnt <= valid_cnt);
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (default build, no bypass): a queue model
// tracks contents cycle by cycle, with hand-computed checkpoints at each scenario.
module tb_inst_buffer;
  localparam int N       = 3;
  localparam int DEPTH   = 16;
  localparam int ENTRY_W = 128;

  logic clock;
  logic reset;

  inst_buffer_if #(.N(N), .DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) bus ();

  inst_buffer #(.N(N), .DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int nid    = 1;
  logic [127:0] cur_pay [N];
  logic [127:0] q [$];

  function automatic logic [127:0] pay(input int id);
    return {32'(id), ~32'(id), 32'(id) ^ 32'h5A5A_5A5A, 32'hB0F0_0000 + 32'(id)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input int dc, input logic fl);
    bus.in_valid       = v;
    bus.dispatch_count = 2'(dc);
    bus.flush          = fl;
    for (int i = 0; i < N; i++) begin
      cur_pay[i] = pay(nid + i);
      bus.in_entries[i*ENTRY_W +: ENTRY_W] = cur_pay[i];
    end
    nid += N;
    #1;
  endtask

  // Compare outputs against the queue model, advance the model, then clock once.
  task automatic step(input string tag);
    int   vc;
    int   pc;
    logic rdy;
    vc  = (q.size() < N) ? q.size() : N;
    rdy = !bus.flush && (q.size() <= DEPTH - N);
    check({tag, " in_ready"},  128'(bus.in_ready),  128'(rdy));
    check({tag, " occupancy"}, 128'(bus.occupancy), 128'(q.size()));
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s valid%0d", tag, i), 128'(bus.out_valid[i]), 128'(i < vc));
      check($sformatf("%s slot%0d", tag, i), bus.out_entries[i*ENTRY_W +: ENTRY_W],
            (i < vc) ? q[i] : 128'h0);
    end
    if (bus.flush) begin
      q.delete();
    end else begin
      pc = (int'(bus.dispatch_count) < vc) ? int'(bus.dispatch_count) : vc;
      repeat (pc) void'(q.pop_front());
      if (rdy)
        for (int i = 0; i < N; i++)
          if (bus.in_valid[i]) q.push_back(cur_pay[i]);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int b;
    reset = 1'b0;
    drive(3'b000, 0, 1'b0);

    // 1: reset held low for two edges, then released
    @(posedge clock); #1;
    check("rst1 out_valid", 128'(bus.out_valid), 128'(3'b000));
    check("rst1 in_ready",  128'(bus.in_ready),  128'(0));
    check("rst1 occupancy", 128'(bus.occupancy), 128'(0));
    @(posedge clock); #1;
    check("rst2 out_valid", 128'(bus.out_valid), 128'(3'b000));
    check("rst2 in_ready",  128'(bus.in_ready),  128'(0));
    check("rst2 occupancy", 128'(bus.occupancy), 128'(0));
    reset = 1'b1;

    // 2: sparse bundle 101 compacts to A,C
    b = nid;
    drive(3'b101, 0, 1'b0);
    check("rel in_ready", 128'(bus.in_ready), 128'(1));
    step("t2 push");
    drive(3'b000, 0, 1'b0);
    check("t2 out_valid", 128'(bus.out_valid), 128'(3'b011));
    check("t2 slot0", bus.out_entries[0 +: ENTRY_W], pay(b));
    check("t2 slot1", bus.out_entries[ENTRY_W +: ENTRY_W], pay(b + 2));
    check("t2 occupancy", 128'(bus.occupancy), 128'(2));
    step("t2 hold");
    drive(3'b000, 2, 1'b0);
    step("t2 drain");

    // 3: fill to 15, stall on credit, then free one bundle's worth
    for (int i = 0; i < 5; i++) begin
      drive(3'b111, 0, 1'b0);
      step($sformatf("t3 fill%0d", i));
    end
    drive(3'b111, 3, 1'b0);
    check("t3 full occupancy", 128'(bus.occupancy), 128'(15));
    check("t3 full in_ready",  128'(bus.in_ready),  128'(0));
    step("t3 pop3");
    drive(3'b000, 0, 1'b0);
    check("t3 after occupancy", 128'(bus.occupancy), 128'(12));
    check("t3 after in_ready",  128'(bus.in_ready),  128'(1));
    step("t3 idle");
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, 3, 1'b0);
      step($sformatf("t3 drain%0d", i));
    end

    // 4: wrap-around across the DEPTH boundary
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 0, 1'b0);
      step($sformatf("t4 pre%0d", i));
    end
    drive(3'b011, 0, 1'b0);
    step("t4 pre4");
    drive(3'b000, 3, 1'b0);
    check("t4 preload occupancy", 128'(bus.occupancy), 128'(14));
    step("t4 pop0");
    for (int i = 1; i < 4; i++) begin
      drive(3'b000, 3, 1'b0);
      step($sformatf("t4 pop%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      drive(3'b111, 2, 1'b0);
      check($sformatf("t4 occ%0d", i), 128'(bus.occupancy), 128'(2 + i));
      step($sformatf("t4 mix%0d", i));
    end
    drive(3'b000, 2, 1'b0);
    check("t4 mixed occupancy", 128'(bus.occupancy), 128'(5));
    step("t4 drain0");
    drive(3'b000, 2, 1'b0);
    step("t4 drain1");
    drive(3'b000, 1, 1'b0);
    step("t4 drain2");

    // 5: push 3 and pop 3 together at occupancy 5
    b = nid;
    drive(3'b111, 0, 1'b0);
    step("t5 fill0");
    drive(3'b011, 0, 1'b0);
    step("t5 fill1");
    drive(3'b111, 3, 1'b0);
    check("t5 pre occupancy", 128'(bus.occupancy), 128'(5));
    step("t5 both");
    drive(3'b000, 0, 1'b0);
    check("t5 occupancy", 128'(bus.occupancy), 128'(5));
    check("t5 slot0", bus.out_entries[0 +: ENTRY_W], pay(b + 3));
    check("t5 slot1", bus.out_entries[ENTRY_W +: ENTRY_W], pay(b + 4));
    check("t5 slot2", bus.out_entries[2*ENTRY_W +: ENTRY_W], pay(b + 6));
    step("t5 hold");

    // 6: flush at occupancy 9 beats a simultaneous push and pop
    drive(3'b111, 0, 1'b0);
    step("t6 fill0");
    drive(3'b001, 0, 1'b0);
    step("t6 fill1");
    drive(3'b111, 2, 1'b1);
    check("t6 pre occupancy", 128'(bus.occupancy), 128'(9));
    check("t6 flush in_ready", 128'(bus.in_ready), 128'(0));
    check("t6 flush out_valid", 128'(bus.out_valid), 128'(3'b111));
    step("t6 flush");
    drive(3'b000, 0, 1'b0);
    check("t6 occupancy", 128'(bus.occupancy), 128'(0));
    check("t6 out_valid", 128'(bus.out_valid), 128'(3'b000));
    check("t6 in_ready",  128'(bus.in_ready),  128'(1));
    step("t6 idle");
    b = nid;
    drive(3'b100, 0, 1'b0);
    step("t6 repush");
    drive(3'b000, 1, 1'b0);
    check("t6 repush occupancy", 128'(bus.occupancy), 128'(1));
    check("t6 repush slot0", bus.out_entries[0 +: ENTRY_W], pay(b + 2));
    step("t6 drain");
    drive(3'b000, 0, 1'b0);
    check("end occupancy", 128'(bus.occupancy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
